// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memory-op codes, access-unit states and per-op byte counts
package mem_pkg;

  localparam logic [2:0] MEMOP_LW  = 3'b000;
  localparam logic [2:0] MEMOP_SW  = 3'b001;
  localparam logic [2:0] MEMOP_LB  = 3'b010;
  localparam logic [2:0] MEMOP_SB  = 3'b011;
  localparam logic [2:0] MEMOP_LBU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDLAST,
    ST_WR,
    ST_RESP
  } mau_state_t;

  // Number of RAM bytes an op touches; 0 marks a code with no RAM access.
  function automatic logic [2:0] op_bytes(input logic [2:0] op);
    case (op)
      MEMOP_LW, MEMOP_SW:             op_bytes = 3'd4;
      MEMOP_LB, MEMOP_SB, MEMOP_LBU:  op_bytes = 3'd1;
      default:                        op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    is_load = (op == MEMOP_LW) || (op == MEMOP_LB) || (op == MEMOP_LBU);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    is_store = (op == MEMOP_SW) || (op == MEMOP_SB);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// rtl/mem_access_unit_load_ext.sv - load result extension (LW / LB sign / LBU zero)
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] bytes,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  // Pick the extension from the latched op; non-loads yield zero.
  always_comb begin
    data = 32'd0;
    case (op)
      MEMOP_LW:  data = bytes;
      MEMOP_LB:  data = {{24{bytes[7]}}, bytes[7:0]};
      MEMOP_LBU: data = {24'd0, bytes[7:0]};
      default:   data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - serializes load/store requests onto a byte-wide RAM; option macro MISALIGN_TRAP_EN
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            MemOp,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  mau_state_t            state;
  logic [1:0]            cnt;
  logic [1:0]            last;
  logic [1:0]            nxt_cnt;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;
  logic [31:0]           ext_in;
  logic [31:0]           ext_out;
  logic                  we_q;
  logic                  known_op;
  logic                  trap;
  logic                  go_resp;

  assign nxt_cnt  = cnt + 2'd1;
  assign known_op = is_load(MemOp) || is_store(MemOp);

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  assign trap    = (((MemOp == MEMOP_LW) || (MemOp == MEMOP_SW)) && (addr[1:0] != 2'b00))
                   || !known_op;
  assign rsp_err = err_q;
`else
  assign trap    = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign go_resp = trap || !known_op;

  // A reset landing mid-store must not commit the byte being written that cycle.
  assign mem_we = we_q && !rst;

  // Final byte is merged straight from the RAM port while leaving RDLAST.
  assign ext_in = buf_q | (32'(mem_rdata) << {cnt, 3'b000});

  load_ext u_load_ext (
    .bytes (ext_in),
    .op    (op_q),
    .data  (ext_out)
  );

  // Transaction FSM; every output is registered on the state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 2'd0;
      last      <= 2'd0;
      op_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      buf_q     <= 32'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rdata     <= 32'd0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
`ifdef MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_q      <= MemOp;
            addr_q    <= addr;
            wdata_q   <= wdata;
            cnt       <= 2'd0;
            last      <= 2'(op_bytes(MemOp) - 3'd1);
            buf_q     <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            err_q     <= trap;
`endif
            if (go_resp) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rdata     <= 32'd0;
            end else if (is_load(MemOp)) begin
              state    <= ST_RD;
              mem_addr <= addr;
            end else begin
              state     <= ST_WR;
              mem_addr  <= addr;
              mem_wdata <= wdata[7:0];
              we_q      <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (cnt != 2'd0) buf_q[{cnt - 2'd1, 3'b000} +: 8] <= mem_rdata;
          if (cnt == last) begin
            state <= ST_RDLAST;
          end else begin
            cnt      <= nxt_cnt;
            mem_addr <= addr_q + ADDR_WIDTH'(nxt_cnt);
          end
        end
        ST_RDLAST: begin
          rdata     <= ext_out;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_WR: begin
          if (cnt == last) begin
            we_q      <= 1'b0;
            rdata     <= 32'd0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt       <= nxt_cnt;
            mem_addr  <= addr_q + ADDR_WIDTH'(nxt_cnt);
            mem_wdata <= wdata_q[{nxt_cnt, 3'b000} +: 8];
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
`ifdef MISALIGN_TRAP_EN
          err_q     <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
